// File: rtl/m_mic_dram_bridge_pkg.sv
// m_mic_dram_bridge_pkg: access codes, access sizes and bridge FSM states shared by the bridge and its bench.
package m_mic_dram_bridge_pkg;
  localparam logic [1:0] ACCESS_CODE  = 2'd0;
  localparam logic [1:0] ACCESS_READ  = 2'd1;
  localparam logic [1:0] ACCESS_WRITE = 2'd2;
  localparam logic [1:0] ACCESS_NONE  = 2'd3;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {MB_IDLE, MB_REQ, MB_WAIT, MB_DONE} mb_state_e;
endpackage

// File: rtl/m_mic_lane_align.sv
// m_mic_lane_align: store byte-lane steering and load extraction/extension from addr[1:0] and funct3.
module m_mic_lane_align
  import m_mic_dram_bridge_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_ctrl,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);
  logic [1:0]  w_sz;
  logic        w_sext;
  logic [15:0] w_sh;
  always_comb begin
    w_sz = i_ctrl[1:0];
    w_sext = ~i_ctrl[2];
    w_sh = 16'(i_rdata >> {i_off, 3'b000});
    o_be = (w_sz == SZ_BYTE) ? 4'b0001 << i_off :
           (w_sz == SZ_HALF) ? 4'b0011 << {i_off[1], 1'b0} : 4'b1111;
    o_wdata = (w_sz == SZ_BYTE) ? {4{i_wdata[7:0]}} :
              (w_sz == SZ_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
    o_rdata = (w_sz == SZ_BYTE) ? {{24{w_sext & w_sh[7]}}, w_sh[7:0]} :
              (w_sz == SZ_HALF) ? {{16{w_sext & w_sh[15]}}, w_sh} : i_rdata;
    o_misalign = (w_sz == SZ_HALF) ? i_off[0] : (w_sz == SZ_BYTE) ? 1'b0 : |i_off;
  end
endmodule

// File: rtl/m_mic_dram_bridge.sv
// m_mic_dram_bridge: turns controller external accesses into one outstanding valid/ready DRAM transaction,
// stalling the controller while it is in flight and returning extracted load data.
module m_mic_dram_bridge
  import m_mic_dram_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] i_mic_addr,
  input  logic [31:0] i_mic_wdata,
  input  logic        i_mic_mmuwe,
  input  logic [2:0]  i_mic_ctrl,
  input  logic [1:0]  i_mic_req,
  output logic        o_stall,
  output logic [31:0] o_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  mb_state_e     r_state, w_next;
  logic [1:0]    r_off, w_off;
  logic [2:0]    r_ctrl, w_ctrl;
  logic [CW-1:0] r_cnt;
  logic          w_launch, w_busy, w_cap, w_fin, w_tout, w_mis;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_rdata;
  // Launch-time lanes come straight from the controller; load extraction uses the latched access.
  always_comb begin
    w_launch = i_mic_mmuwe || (i_mic_req == ACCESS_READ && |i_mic_addr[31:28]);
    w_busy = r_state == MB_REQ || r_state == MB_WAIT;
    w_off = (r_state == MB_IDLE) ? i_mic_addr[1:0] : r_off;
    w_ctrl = (r_state == MB_IDLE) ? i_mic_ctrl : r_ctrl;
    w_cap = (r_state == MB_REQ && i_mem_ready && !o_mem_we && i_mem_rvalid) ||
            (r_state == MB_WAIT && i_mem_rvalid);
    w_fin = w_cap || (r_state == MB_REQ && i_mem_ready && o_mem_we);
    w_tout = w_busy && r_cnt == CNT_MAX && !w_fin;
  end
  m_mic_lane_align u_align (
    .i_off      (w_off),
    .i_ctrl     (w_ctrl),
    .i_wdata    (i_mic_wdata),
    .i_rdata    (i_mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_mis)
  );
  always_ff @(posedge CLK) begin
    if (RST) r_state <= MB_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      MB_IDLE: w_next = w_launch ? MB_REQ : MB_IDLE;
      MB_REQ, MB_WAIT: w_next = (w_fin || w_tout) ? MB_DONE : i_mem_ready ? MB_WAIT : r_state;
      default: w_next = MB_IDLE;
    endcase
  end
  always_comb begin
    o_stall = !RST && (w_busy || (r_state == MB_IDLE && w_launch));
    o_mem_req = r_state == MB_REQ;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_off <= '0;
      r_ctrl <= '0;
      r_cnt <= '0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
      o_mem_be <= '0;
      o_data <= '0;
      o_err <= 1'b0;
    end else begin
      if (r_state == MB_IDLE && w_launch) begin
        r_off <= i_mic_addr[1:0];
        r_ctrl <= i_mic_ctrl;
        r_cnt <= '0;
        o_mem_we <= i_mic_mmuwe;
        o_mem_addr <= {i_mic_addr[31:2], 2'b00};
        o_mem_be <= w_be;
        o_mem_wdata <= w_wdata;
        if (w_mis) o_err <= 1'b1;
      end
      if (w_busy) r_cnt <= r_cnt + 1'b1;
      if (w_cap) o_data <= w_rdata;
      if (w_tout) begin
        o_data <= '0;
        o_err <= 1'b1;
      end
    end
  end
endmodule
